// File: rtl/uart_xcvr_param.sv
// uart_xcvr_param: parametrised full-duplex UART transceiver with valid/ready on both sides.
// Ports: clk, rst (sync, active high), baud_div[15:0] (clk per bit, clamped to >=4),
//   tx_data/tx_valid/tx_ready (transmit handshake),
//   rx_data/rx_valid/rx_ready + rx_frame_err/rx_par_err/rx_overrun (receive handshake),
//   rs232_rx (async serial in), rs232_tx (registered serial out, idle high).
// Optional parity bit is enabled by defining UART_PARITY_EN.
module uart_xcvr_param #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int MSB_FIRST  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          baud_div,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_par_err,
  output logic                 rx_overrun,
  input  logic                 rs232_rx,
  output logic                 rs232_tx
);
`ifdef UART_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic [15:0] div_c;
  assign div_c = baud_div < 16'd4 ? 16'd4 : baud_div;
  state_t tx_st_q;
  logic tx_q, tx_rdy_q, tx_par_q;
  logic [15:0] tx_cnt_q, tx_div_q;
  logic [3:0] tx_idx_q;
  logic [DATA_BITS-1:0] tx_sh_q, tx_rev;
  // The shifter always emits bit 0 first, so MSB-first words are loaded reversed.
  assign tx_rev = {<<{tx_data}};
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st_q  <= IDLE;
      tx_q     <= 1'b1;
      tx_rdy_q <= 1'b1;
      tx_cnt_q <= '0;
      tx_div_q <= 16'd4;
      tx_idx_q <= '0;
      tx_sh_q  <= '0;
      tx_par_q <= 1'b0;
    end else if (tx_st_q == IDLE) begin
      if (tx_valid) begin
        tx_st_q  <= START;
        tx_q     <= 1'b0;
        tx_rdy_q <= 1'b0;
        tx_cnt_q <= '0;
        tx_div_q <= div_c;
        tx_sh_q  <= MSB_FIRST != 0 ? tx_rev : tx_data;
        tx_par_q <= ^tx_data ^ 1'(PARITY_ODD);
      end
    end else if (tx_cnt_q != tx_div_q - 16'd1) begin
      tx_cnt_q <= tx_cnt_q + 16'd1;
    end else begin
      tx_cnt_q <= '0;
      tx_idx_q <= tx_idx_q + 4'd1;
      case (tx_st_q)
        START: begin
          tx_st_q  <= DATA;
          tx_idx_q <= '0;
          tx_q     <= tx_sh_q[0];
          tx_sh_q  <= tx_sh_q >> 1;
        end
        DATA:
          if (tx_idx_q == 4'(DATA_BITS - 1)) begin
            tx_st_q  <= (P != 0) ? PARITY : STOP;
            tx_idx_q <= '0;
            tx_q     <= (P != 0) ? tx_par_q : 1'b1;
          end else begin
            tx_q    <= tx_sh_q[0];
            tx_sh_q <= tx_sh_q >> 1;
          end
        PARITY: begin
          tx_st_q  <= STOP;
          tx_idx_q <= '0;
          tx_q     <= 1'b1;
        end
        default:
          if (tx_idx_q == 4'(STOP_BITS - 1)) begin
            tx_st_q  <= IDLE;
            tx_rdy_q <= 1'b1;
          end
      endcase
    end
  end
  assign rs232_tx = tx_q;
  assign tx_ready = tx_rdy_q;
  logic s1_q, s2_q, prev_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= rs232_rx;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end
  state_t rx_st_q;
  logic [15:0] rx_cnt_q, rx_div_q;
  logic [3:0] rx_idx_q;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d, rx_data_q;
  logic rx_valid_q, rx_fe_q, rx_ov_q;
  always_comb rx_sh_d = MSB_FIRST != 0 ? {rx_sh_q[DATA_BITS-2:0], s2_q} : {s2_q, rx_sh_q[DATA_BITS-1:1]};
`ifdef UART_PARITY_EN
  logic rx_pb_q, rx_pe_q;
  assign rx_par_err = rx_pe_q;
`else
  assign rx_par_err = 1'b0;
`endif
  // A start needs a high-to-low transition, so after a break the receiver stays
  // disarmed until the line has been seen high for at least one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st_q    <= IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= 16'd4;
      rx_idx_q   <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_fe_q    <= 1'b0;
      rx_ov_q    <= 1'b0;
`ifdef UART_PARITY_EN
      rx_pb_q    <= 1'b0;
      rx_pe_q    <= 1'b0;
`endif
    end else begin
      if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
        rx_fe_q    <= 1'b0;
        rx_ov_q    <= 1'b0;
`ifdef UART_PARITY_EN
        rx_pe_q    <= 1'b0;
`endif
      end
      case (rx_st_q)
        IDLE:
          if (prev_q && !s2_q) begin
            rx_st_q  <= START;
            rx_cnt_q <= '0;
            rx_div_q <= div_c;
          end
        START:
          if (rx_cnt_q == (rx_div_q >> 1) - 16'd1) begin
            rx_cnt_q <= '0;
            rx_idx_q <= '0;
            rx_st_q  <= s2_q ? IDLE : DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        default:
          if (rx_cnt_q != rx_div_q - 16'd1) begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end else begin
            rx_cnt_q <= '0;
            if (rx_st_q == DATA) begin
              rx_sh_q  <= rx_sh_d;
              rx_idx_q <= rx_idx_q + 4'd1;
              if (rx_idx_q == 4'(DATA_BITS - 1)) rx_st_q <= (P != 0) ? PARITY : STOP;
            end else if (rx_st_q == PARITY) begin
`ifdef UART_PARITY_EN
              rx_pb_q <= s2_q;
`endif
              rx_st_q <= STOP;
            end else begin
              // Leave at mid stop bit so a fast sender's next start edge is not missed.
              rx_st_q    <= IDLE;
              rx_data_q  <= rx_sh_q;
              rx_valid_q <= 1'b1;
              rx_fe_q    <= !s2_q;
              rx_ov_q    <= rx_valid_q && !rx_ready;
`ifdef UART_PARITY_EN
              rx_pe_q    <= ^rx_sh_q ^ rx_pb_q ^ 1'(PARITY_ODD);
`endif
            end
          end
      endcase
    end
  end
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_fe_q;
  assign rx_overrun   = rx_ov_q;
endmodule
